branch_predictor: RTL and testbench

- Fetch-stage predictor paired with the computational-stage branch resolver.
- A direct-mapped table of 2-bit saturating counters plus a branch target buffer predicts taken/not-taken and the target for the fetch PC.
- At the other end, the resolved outcome from the computational stage trains the table and raises a mispredict/redirect when the earlier prediction was wrong.

---
 rtl/branch_predictor.sv | 117 +++++++++++
 tb/tb_branch_predictor.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped 2-bit counter table with a BTB,
// trained by the computational-stage resolver, which also raises redirects.
module branch_predictor #(
  parameter  int XLEN    = 32,
  parameter  int ENTRIES = 16,
  parameter  int CNT_W   = 32,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  PC_I,
  output logic             PredictTaken_I,
  output logic [XLEN-1:0]  PredictTarget_I,
  input  logic             BranchValid_C,
  input  logic             BranchTaken_C,
  input  logic [XLEN-1:0]  PC_C,
  input  logic [XLEN-1:0]  BranchTarget_C,
  input  logic             PredictedTaken_C,
  input  logic [XLEN-1:0]  PredictedTarget_C,
  output logic             Mispredict_C,
  output logic [XLEN-1:0]  CorrectPC_C,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredictCount
);

  localparam int TAG_W = XLEN - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [1:0]       cnt_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             rd_hit, wr_hit;

  // Instructions are word aligned, so the byte-offset bits carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PC_I[1:0], PC_C[1:0]};

  assign rd_idx = PC_I[IDX_W+1:2];
  assign rd_tag = PC_I[XLEN-1:IDX_W+2];
  assign wr_idx = PC_C[IDX_W+1:2];
  assign wr_tag = PC_C[XLEN-1:IDX_W+2];

  assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  // Prediction reads only registered state, so a same-cycle update is not seen.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    PredictTaken_I  = 1'b0;
    PredictTarget_I = PC_I + XLEN'(4);
    if (rd_hit && cnt_q[rd_idx][1]) begin
      PredictTaken_I  = 1'b1;
      PredictTarget_I = target_q[rd_idx];
    end
  end

  assign Mispredict_C = BranchValid_C &&
                        ((BranchTaken_C != PredictedTaken_C) ||
                         (BranchTaken_C && PredictedTaken_C &&
                          (BranchTarget_C != PredictedTarget_C)));

  assign CorrectPC_C = BranchTaken_C ? BranchTarget_C : PC_C + XLEN'(4);

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  // NOTE: the table is reset entry by entry because a cold predictor must
  // read as not-taken; the loop is plain flops, not a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // update from the same pre-edge values.
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        cnt_q[i]    <= 2'b01;
        target_q[i] <= '0;
      end
    end else if (BranchValid_C) begin
      if (wr_hit) begin
        if (BranchTaken_C) begin
          cnt_q[wr_idx]    <= sat_inc(cnt_q[wr_idx]);
          target_q[wr_idx] <= BranchTarget_C;
        end else begin
          cnt_q[wr_idx]    <= sat_dec(cnt_q[wr_idx]);
        end
      end else if (BranchTaken_C) begin
        valid_q[wr_idx]  <= 1'b1;
        tag_q[wr_idx]    <= wr_tag;
        cnt_q[wr_idx]    <= 2'b10;
        target_q[wr_idx] <= BranchTarget_C;
      end
    end
  end

  // Performance counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      BranchCount     <= '0;
      MispredictCount <= '0;
    end else begin
      if (BranchValid_C && (BranchCount != '1))
        BranchCount <= BranchCount + CNT_W'(1);
      if (Mispredict_C && (MispredictCount != '1))
        MispredictCount <= MispredictCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_I;
  logic        PredictTaken_I;
  logic [31:0] PredictTarget_I;
  logic        BranchValid_C;
  logic        BranchTaken_C;
  logic [31:0] PC_C;
  logic [31:0] BranchTarget_C;
  logic        PredictedTaken_C;
  logic [31:0] PredictedTarget_C;
  logic        Mispredict_C;
  logic [31:0] CorrectPC_C;
  logic [31:0] BranchCount;
  logic [31:0] MispredictCount;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(32), .ENTRIES(16), .CNT_W(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .PC_I              (PC_I),
    .PredictTaken_I    (PredictTaken_I),
    .PredictTarget_I   (PredictTarget_I),
    .BranchValid_C     (BranchValid_C),
    .BranchTaken_C     (BranchTaken_C),
    .PC_C              (PC_C),
    .BranchTarget_C    (BranchTarget_C),
    .PredictedTaken_C  (PredictedTaken_C),
    .PredictedTarget_C (PredictedTarget_C),
    .Mispredict_C      (Mispredict_C),
    .CorrectPC_C       (CorrectPC_C),
    .BranchCount       (BranchCount),
    .MispredictCount   (MispredictCount)
  );

  // Advance one clock; inputs then change 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                         input logic ptaken, input logic [31:0] ptgt);
    BranchValid_C     = 1'b1;
    PC_C              = pc;
    BranchTaken_C     = taken;
    BranchTarget_C    = tgt;
    PredictedTaken_C  = ptaken;
    PredictedTarget_C = ptgt;
    #1;
  endtask

  task automatic idle();
    BranchValid_C = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
    PC_I  = 32'h100;
    #1;
    total++; if (PredictTaken_I !== 1'b0) begin bad++; $display("FAIL reset_taken got=%0h exp=0", PredictTaken_I); end
    total++; if (PredictTarget_I !== 32'h104) begin bad++; $display("FAIL reset_target got=%0h exp=104", PredictTarget_I); end
    total++; if (BranchCount !== 32'd0) begin bad++; $display("FAIL reset_bcnt got=%0d exp=0", BranchCount); end
    total++; if (MispredictCount !== 32'd0) begin bad++; $display("FAIL reset_mcnt got=%0d exp=0", MispredictCount); end
  endtask

  task automatic test_allocate();
    resolve(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    total++; if (Mispredict_C !== 1'b1) begin bad++; $display("FAIL alloc_mispredict got=%0h exp=1", Mispredict_C); end
    total++; if (CorrectPC_C !== 32'h80) begin bad++; $display("FAIL alloc_correctpc got=%0h exp=80", CorrectPC_C); end
    step();
    idle();
    PC_I = 32'h100;
    #1;
    total++; if (PredictTaken_I !== 1'b1) begin bad++; $display("FAIL alloc_taken got=%0h exp=1", PredictTaken_I); end
    total++; if (PredictTarget_I !== 32'h80) begin bad++; $display("FAIL alloc_target got=%0h exp=80", PredictTarget_I); end
    total++; if (MispredictCount !== 32'd1) begin bad++; $display("FAIL alloc_mcnt got=%0d exp=1", MispredictCount); end
  endtask

  task automatic test_training();
    for (int i = 0; i < 3; i++) begin
      resolve(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      total++; if (Mispredict_C !== 1'b0) begin bad++; $display("FAIL train_hit%0d got=%0h exp=0", i, Mispredict_C); end
      step();
    end
    resolve(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    total++; if (Mispredict_C !== 1'b1) begin bad++; $display("FAIL train_nt_mispredict got=%0h exp=1", Mispredict_C); end
    total++; if (CorrectPC_C !== 32'h104) begin bad++; $display("FAIL train_nt_correctpc got=%0h exp=104", CorrectPC_C); end
    step();
    idle();
    #1;
    total++; if (PredictTaken_I !== 1'b1) begin bad++; $display("FAIL train_cnt10_taken got=%0h exp=1", PredictTaken_I); end
    total++; if (PredictTarget_I !== 32'h80) begin bad++; $display("FAIL train_cnt10_target got=%0h exp=80", PredictTarget_I); end
    resolve(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    step();
    idle();
    #1;
    total++; if (PredictTaken_I !== 1'b0) begin bad++; $display("FAIL train_cnt01_taken got=%0h exp=0", PredictTaken_I); end
    total++; if (PredictTarget_I !== 32'h104) begin bad++; $display("FAIL train_cnt01_target got=%0h exp=104", PredictTarget_I); end
    total++; if (BranchCount !== 32'd6) begin bad++; $display("FAIL train_bcnt got=%0d exp=6", BranchCount); end
    total++; if (MispredictCount !== 32'd3) begin bad++; $display("FAIL train_mcnt got=%0d exp=3", MispredictCount); end
  endtask

  task automatic test_alias();
    resolve(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    step();
    resolve(32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
    step();
    idle();
    PC_I = 32'h100;
    #1;
    total++; if (PredictTaken_I !== 1'b0) begin bad++; $display("FAIL alias_old_taken got=%0h exp=0", PredictTaken_I); end
    total++; if (PredictTarget_I !== 32'h104) begin bad++; $display("FAIL alias_old_target got=%0h exp=104", PredictTarget_I); end
    PC_I = 32'h140;
    #1;
    total++; if (PredictTaken_I !== 1'b1) begin bad++; $display("FAIL alias_new_taken got=%0h exp=1", PredictTaken_I); end
    total++; if (PredictTarget_I !== 32'h200) begin bad++; $display("FAIL alias_new_target got=%0h exp=200", PredictTarget_I); end
  endtask

  task automatic test_target_mismatch();
    resolve(32'h108, 1'b1, 32'h80, 1'b0, 32'h10c);
    step();
    resolve(32'h108, 1'b1, 32'h90, 1'b1, 32'h80);
    total++; if (Mispredict_C !== 1'b1) begin bad++; $display("FAIL tgt_mispredict got=%0h exp=1", Mispredict_C); end
    total++; if (CorrectPC_C !== 32'h90) begin bad++; $display("FAIL tgt_correctpc got=%0h exp=90", CorrectPC_C); end
    step();
    idle();
    PC_I = 32'h108;
    #1;
    total++; if (PredictTarget_I !== 32'h90) begin bad++; $display("FAIL tgt_stored got=%0h exp=90", PredictTarget_I); end
    total++; if (MispredictCount !== 32'd7) begin bad++; $display("FAIL tgt_mcnt got=%0d exp=7", MispredictCount); end
  endtask

  task automatic test_same_cycle();
    resolve(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    step();
    PC_I = 32'h100;
    resolve(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    total++; if (PredictTaken_I !== 1'b1) begin bad++; $display("FAIL same_old_taken got=%0h exp=1", PredictTaken_I); end
    total++; if (PredictTarget_I !== 32'h80) begin bad++; $display("FAIL same_old_target got=%0h exp=80", PredictTarget_I); end
    step();
    idle();
    #1;
    total++; if (PredictTaken_I !== 1'b0) begin bad++; $display("FAIL same_new_taken got=%0h exp=0", PredictTaken_I); end
    total++; if (BranchCount !== 32'd12) begin bad++; $display("FAIL same_bcnt got=%0d exp=12", BranchCount); end
  endtask

  task automatic test_reset_with_update();
    reset = 1'b1;
    resolve(32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
    total++; if (Mispredict_C !== 1'b1) begin bad++; $display("FAIL rstupd_mispredict got=%0h exp=1", Mispredict_C); end
    step();
    reset = 1'b0;
    idle();
    PC_I = 32'h200;
    #1;
    total++; if (PredictTaken_I !== 1'b0) begin bad++; $display("FAIL rstupd_noalloc got=%0h exp=0", PredictTaken_I); end
    PC_I = 32'h108;
    #1;
    total++; if (PredictTaken_I !== 1'b0) begin bad++; $display("FAIL rstupd_cleared got=%0h exp=0", PredictTaken_I); end
    total++; if (BranchCount !== 32'd0) begin bad++; $display("FAIL rstupd_bcnt got=%0d exp=0", BranchCount); end
    total++; if (MispredictCount !== 32'd0) begin bad++; $display("FAIL rstupd_mcnt got=%0d exp=0", MispredictCount); end
  endtask

  task automatic test_edges();
    // Invalid branch: no redirect, nothing counted.
    BranchValid_C     = 1'b0;
    BranchTaken_C     = 1'b1;
    PredictedTaken_C  = 1'b0;
    #1;
    total++; if (Mispredict_C !== 1'b0) begin bad++; $display("FAIL idle_mispredict got=%0h exp=0", Mispredict_C); end
    step();
    total++; if (BranchCount !== 32'd0) begin bad++; $display("FAIL idle_bcnt got=%0d exp=0", BranchCount); end
    // Fall-through address wraps at the top of the address space.
    PC_I = 32'hffff_fffc;
    resolve(32'hffff_fffc, 1'b0, 32'h40, 1'b1, 32'h40);
    total++; if (PredictTarget_I !== 32'h0) begin bad++; $display("FAIL wrap_target got=%0h exp=0", PredictTarget_I); end
    total++; if (CorrectPC_C !== 32'h0) begin bad++; $display("FAIL wrap_correctpc got=%0h exp=0", CorrectPC_C); end
    step();
    // Byte-offset bits of the PC do not affect the lookup.
    resolve(32'h300, 1'b1, 32'h400, 1'b0, 32'h304);
    step();
    idle();
    PC_I = 32'h302;
    #1;
    total++; if (PredictTaken_I !== 1'b1) begin bad++; $display("FAIL offset_taken got=%0h exp=1", PredictTaken_I); end
    total++; if (PredictTarget_I !== 32'h400) begin bad++; $display("FAIL offset_target got=%0h exp=400", PredictTarget_I); end
    total++; if (BranchCount !== 32'd2) begin bad++; $display("FAIL edges_bcnt got=%0d exp=2", BranchCount); end
  endtask

  initial begin
    reset             = 1'b1;
    PC_I              = '0;
    BranchValid_C     = 1'b0;
    BranchTaken_C     = 1'b0;
    PC_C              = '0;
    BranchTarget_C    = '0;
    PredictedTaken_C  = 1'b0;
    PredictedTarget_C = '0;
    #1;
    test_reset();
    test_allocate();
    test_training();
    test_alias();
    test_target_mismatch();
    test_same_cycle();
    test_reset_with_update();
    test_edges();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
